// File: rtl/rr_arbiter_encoder_pkg.sv
// Shared types and helpers for the round-robin arbiter/encoder.
//   state_t : arbiter FSM state (IDLE = no grant, GRANT = one owner holds the resource)
//   idx_w() : width of a binary index for w requesters (at least 1 bit)
package rr_arbiter_encoder_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic int idx_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_encoder_pick.sv
// rr_pick: combinational rotating priority encoder.
// Finds the first set request in the order ptr, ptr+1, ..., W-1, 0, ..., ptr-1.
//   req   in  W   request vector
//   ptr   in  IW  search start index (0 <= ptr < W)
//   found out 1   any request set
//   idx   out IW  index of the first request at or after ptr (wrapping modulo W)
module rr_pick
   import rr_arbiter_encoder_pkg::*;
#(
   parameter  int W  = 4,
   localparam int IW = idx_w(W)
) (
   input  logic [W-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [W-1:0]   mask;
   logic [2*W-1:0] dbl;

   always_comb begin
      // Low half holds only requests at or above ptr, so it wins the
      // lowest-index search; the unmasked high half supplies the wrap.
      mask  = ~((W'(1) << ptr) - W'(1));
      dbl   = {req, req & mask};
      found = |req;
      idx   = '0;
      for (int i = 2*W-1; i >= 0; i--) begin
         if (dbl[i]) idx = IW'(i % W);
      end
   end

endmodule

// File: rtl/rr_arbiter_encoder.sv
// rr_arbiter_encoder: round-robin arbiter with one-hot grant and binary grant index.
// A grant locks while its owner keeps requesting; on release the next owner is searched
// starting one past the previous owner, with no idle cycle between owners.
// Optional feature macro: RR_ARBITER_ENCODER_TIMEOUT_EN -- bounds the lock to MAX_HOLD
// cycles whenever another requester is waiting.
//   clk       in  1   clock, rising edge
//   rst       in  1   synchronous active-high reset
//   req       in  W   level requests
//   gnt       out W   registered one-hot grant, zero when idle
//   gnt_idx   out IW  binary index of the owner (meaningful when gnt_valid)
//   gnt_valid out 1   a grant is active
module rr_arbiter_encoder
   import rr_arbiter_encoder_pkg::*;
#(
   parameter  int W        = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IW       = idx_w(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  req,
   output logic [W-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_valid
);

   if (W < 1 || MAX_HOLD < 2) begin : g_bad_params
      $error("rr_arbiter_encoder: need W >= 1 and MAX_HOLD >= 2");
   end

   state_t        state, nxt_state;
   logic [IW-1:0] ptr, nxt_ptr, nxt_idx, succ, base, pick_idx;
   logic [W-1:0]  nxt_gnt, cand;
   logic          pick_found, owner_req, handoff;

`ifdef RR_ARBITER_ENCODER_TIMEOUT_EN
   localparam int            HW       = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
   logic [HW-1:0] hold_cnt, nxt_hold;
`endif

   // Search base: stored ptr when idle, one past the owner while granted.
   // The owner is masked out so a forced handoff never lands back on it.
   always_comb begin
      owner_req = |(req & gnt);
      succ      = (int'(gnt_idx) == W - 1) ? '0 : gnt_idx + IW'(1);
      base      = (state == GRANT) ? succ : ptr;
      cand      = (state == GRANT) ? (req & ~gnt) : req;
`ifdef RR_ARBITER_ENCODER_TIMEOUT_EN
      handoff   = owner_req && (hold_cnt == HOLD_MAX);
`else
      handoff   = 1'b0;
`endif
   end

   rr_pick #(.W(W)) u_pick (
      .req   (cand),
      .ptr   (base),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // State register (with the datapath registers that move with it)
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
      end else begin
         state   <= nxt_state;
         ptr     <= nxt_ptr;
         gnt     <= nxt_gnt;
         gnt_idx <= nxt_idx;
      end
   end

   // Next-state logic
   always_comb begin
      nxt_state = state;
      nxt_ptr   = ptr;
      nxt_gnt   = gnt;
      nxt_idx   = gnt_idx;
      case (state)
         IDLE: begin
            if (pick_found) begin
               nxt_state = GRANT;
               nxt_idx   = pick_idx;
               nxt_gnt   = W'(1) << pick_idx;
            end
         end
         GRANT: begin
            if (!owner_req || (handoff && pick_found)) begin
               nxt_ptr = succ;
               if (pick_found) begin
                  nxt_idx = pick_idx;
                  nxt_gnt = W'(1) << pick_idx;
               end else begin
                  nxt_state = IDLE;
                  nxt_idx   = '0;
                  nxt_gnt   = '0;
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      gnt_valid = (state == GRANT);
   end

`ifdef RR_ARBITER_ENCODER_TIMEOUT_EN
   // A new owner always enters from IDLE or with a different index, since
   // a releasing owner's request is low and cannot be picked again.
   always_comb begin
      nxt_hold = hold_cnt;
      if (nxt_state == GRANT && (state == IDLE || nxt_idx != gnt_idx))
         nxt_hold = '0;
      else if (state == GRANT && hold_cnt != HOLD_MAX)
         nxt_hold = hold_cnt + HW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) hold_cnt <= '0;
      else     hold_cnt <= nxt_hold;
   end
`endif

endmodule

// File: tb/tb_rr_arbiter_encoder.sv
// Bench for rr_arbiter_encoder: directed table, hand sequences for lock and W=5 wrap,
// then random traffic against an arithmetic round-robin model (W=4 and W=5 instances).
module tb_rr_arbiter_encoder;

   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req4, gnt4;
   logic [1:0] idx4;
   logic       v4;
   logic [4:0] req5, gnt5;
   logic [2:0] idx5;
   logic       v5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_arbiter_encoder #(.W(4), .MAX_HOLD(MAX_HOLD)) dut4 (
      .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(v4)
   );

   rr_arbiter_encoder #(.W(5), .MAX_HOLD(MAX_HOLD)) dut5 (
      .clk(clk), .rst(rst), .req(req5), .gnt(gnt5), .gnt_idx(idx5), .gnt_valid(v5)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       vld;
   } vec_t;

   vec_t tbl[17];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // First requester at or after start, walking modulo w; -1 if none.
   function automatic int find(input int w, input logic [7:0] rq, input int start);
      for (int k = 0; k < w; k++) begin
         if (rq[(start + k) % w]) return (start + k) % w;
      end
      return -1;
   endfunction

   task automatic mstep(input int w, input logic rs, input logic [7:0] rq,
                        inout int owner, inout int ptr, inout int hold);
      logic [7:0] others;
      if (rs) begin
         owner = -1; ptr = 0; hold = 0;
      end else if (owner < 0) begin
         owner = find(w, rq, ptr); hold = 0;
      end else if (!rq[owner]) begin
         ptr = (owner + 1) % w; owner = find(w, rq, ptr); hold = 0;
      end else begin
         others = rq;
         others[owner] = 1'b0;
`ifdef RR_ARBITER_ENCODER_TIMEOUT_EN
         if (hold == MAX_HOLD - 1 && others != 0) begin
            ptr = (owner + 1) % w; owner = find(w, others, ptr); hold = 0;
         end else if (hold < MAX_HOLD - 1) begin
            hold++;
         end
`else
         hold = hold + ((others != 0) ? 0 : 0);
`endif
      end
   endtask

   int o4, p4, h4, o5, p5, h5;

   initial begin
      rst  = 1'b1;
      req4 = '0;
      req5 = '0;

      //          rst   req      gnt      idx   vld
      tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
      tbl[3]  = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1};
      tbl[4]  = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1};
      tbl[5]  = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1};
      tbl[6]  = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1};
      tbl[7]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[10] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[11] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
      tbl[12] = '{1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0};
      tbl[13] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1};
      tbl[14] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[15] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[16] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};

      for (int i = 0; i < 17; i++) begin
         rst  = tbl[i].rst;
         req4 = tbl[i].req;
         tick();
         chk($sformatf("tbl%0d_gnt", i), 32'(gnt4), 32'(tbl[i].gnt));
         chk($sformatf("tbl%0d_vld", i), 32'(v4), 32'(tbl[i].vld));
         if (tbl[i].vld || tbl[i].rst)
            chk($sformatf("tbl%0d_idx", i), 32'(idx4), 32'(tbl[i].idx));
      end

      // Lock: owner 2 keeps requesting while everyone else asks too.
      req4 = 4'b0100;
      tick();
      chk("lock_start", 32'(gnt4), 32'h4);
      req4 = 4'b1111;
      for (int k = 1; k <= 20; k++) begin
         tick();
`ifdef RR_ARBITER_ENCODER_TIMEOUT_EN
         if (k < MAX_HOLD)       chk($sformatf("lock_k%0d", k), 32'(gnt4), 32'h4);
         else if (k == MAX_HOLD) chk("lock_timeout", 32'(gnt4), 32'h8);
`else
         chk($sformatf("lock_k%0d", k), 32'(gnt4), 32'h4);
`endif
      end
      req4 = 4'b0000;
      tick();
      chk("lock_release_vld", 32'(v4), 32'h0);

      // W=5 wrap: bring ptr to 1, then 4 must beat 0; after release 0 follows.
      req5 = 5'b00001;
      tick();
      chk("w5_first", 32'(gnt5), 32'h01);
      req5 = 5'b00000;
      tick();
      chk("w5_idle", 32'(v5), 32'h0);
      req5 = 5'b10001;
      tick();
      chk("w5_idx4", 32'(idx5), 32'd4);
      chk("w5_gnt4", 32'(gnt5), 32'h10);
      req5 = 5'b00001;
      tick();
      chk("w5_idx0", 32'(idx5), 32'd0);
      chk("w5_gnt0", 32'(gnt5), 32'h01);

      // Random traffic against the model.
      rst  = 1'b1;
      req4 = '0;
      req5 = '0;
      o4 = -1; p4 = 0; h4 = 0;
      o5 = -1; p5 = 0; h5 = 0;
      tick();
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 5) == 0) req4 = 4'($urandom);
         if ($urandom_range(0, 5) == 0) req5 = 5'($urandom);
         mstep(4, rst, {4'b0, req4}, o4, p4, h4);
         mstep(5, rst, {3'b0, req5}, o5, p5, h5);
         tick();
         chk($sformatf("rnd%0d_gnt4", c), 32'(gnt4), (o4 < 0) ? 32'h0 : (32'h1 << o4));
         chk($sformatf("rnd%0d_vld4", c), 32'(v4), (o4 < 0) ? 32'h0 : 32'h1);
         if (o4 >= 0) chk($sformatf("rnd%0d_idx4", c), 32'(idx4), 32'(o4));
         chk($sformatf("rnd%0d_gnt5", c), 32'(gnt5), (o5 < 0) ? 32'h0 : (32'h1 << o5));
         chk($sformatf("rnd%0d_vld5", c), 32'(v5), (o5 < 0) ? 32'h0 : 32'h1);
         if (o5 >= 0) chk($sformatf("rnd%0d_idx5", c), 32'(idx5), 32'(o5));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
